// File: rtl/ksort_merge_pkg.sv
// rtl/ksort_merge_pkg.sv - shared state encoding and width helpers for the k-way sorted merge
package ksort_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        EMIT,
        FLUSH,
        DONE
    } state_t;

    // Channel index width; a single channel still needs one bit to index.
    function automatic int chIdxW(input int numCh);
        return (numCh > 1) ? $clog2(numCh) : 1;
    endfunction

    // Result counter width, able to hold the value K itself.
    function automatic int cntW(input int k);
        return $clog2(k + 1);
    endfunction

    localparam int CH_IDX_W = chIdxW(4);
    localparam int CNT_W    = cntW(8);

endpackage

// File: rtl/ksort_merge_if.sv
// rtl/ksort_merge_if.sv - per-channel input streams and merged result handshake
interface ksort_merge_if #(
    parameter int VAL_WIDTH  = 32,
    parameter int NAME_WIDTH = 32,
    parameter int NUM_CH     = 4
);
    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH-1:0]            in_ready;
    logic [NUM_CH*VAL_WIDTH-1:0]  in_value;
    logic [NUM_CH*NAME_WIDTH-1:0] in_name;
    logic [NUM_CH-1:0]            in_last;
    logic                         out_valid;
    logic                         out_ready;
    logic [VAL_WIDTH-1:0]         out_value;
    logic [NAME_WIDTH-1:0]        out_name;
    logic                         out_last;

    // Merge engine side.
    modport slave (
        input  in_valid, in_value, in_name, in_last, out_ready,
        output in_ready, out_valid, out_value, out_name, out_last
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_value, in_name, in_last, out_ready,
        input  in_ready, out_valid, out_value, out_name, out_last
    );
endinterface

// File: rtl/ksort_merge_min_sel.sv
// rtl/ksort_merge_min_sel.sv - combinational argmin over the channel head registers
module ksort_min_sel
    import ksort_pkg::*;
#(
    parameter int VAL_WIDTH = 32,
    parameter int NUM_CH    = 4,
    parameter int IDX_W     = chIdxW(NUM_CH)
) (
    input  logic [NUM_CH*VAL_WIDTH-1:0] values,
    input  logic [NUM_CH-1:0]           fullMask,
    output logic [IDX_W-1:0]            minIdx
);
    logic [VAL_WIDTH-1:0] best;
    logic                 found;

    // Strict less-than while scanning upward keeps ties on the lowest channel.
    always_comb begin
        minIdx = '0;
        best   = '0;
        found  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (fullMask[c] && (!found || values[c*VAL_WIDTH +: VAL_WIDTH] < best)) begin
                best   = values[c*VAL_WIDTH +: VAL_WIDTH];
                minIdx = IDX_W'(c);
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ksort_merge.sv
// rtl/ksort_merge.sv - merges NUM_CH ascending lists into the K smallest results; KSORT_MERGE_ORDER_CHECK_EN adds input order checking
module ksort_merge
    import ksort_pkg::*;
#(
    parameter int VAL_WIDTH  = 32,
    parameter int NAME_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int K          = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    ksort_merge_if.slave bus,
    output logic         done,
    output logic         order_err
);
    localparam int IDX_W = chIdxW(NUM_CH);
    localparam int CW    = cntW(K);

    state_t                       state, nextState;
    logic [NUM_CH*VAL_WIDTH-1:0]  headValue;
    logic [NUM_CH*NAME_WIDTH-1:0] headName;
    logic [NUM_CH-1:0]            headLast;
    logic [NUM_CH-1:0]            headFull;
    logic [NUM_CH-1:0]            exhausted;
    logic [CW-1:0]                count;
    logic [IDX_W-1:0]             selIdx;
    logic [NUM_CH-1:0]            selMask;
    logic [NUM_CH-1:0]            accept;
    logic [NUM_CH-1:0]            exhaustedAfterPop;
    logic                         allReady;
    logic                         emitLast;
    logic                         xfer;
    logic                         loadOut;

    ksort_min_sel #(
        .VAL_WIDTH (VAL_WIDTH),
        .NUM_CH    (NUM_CH),
        .IDX_W     (IDX_W)
    ) uMinSel (
        .values   (headValue),
        .fullMask (headFull),
        .minIdx   (selIdx)
    );

    assign selMask           = NUM_CH'(1) << selIdx;
    assign allReady          = &(headFull | exhausted);
    assign exhaustedAfterPop = exhausted | (headLast & selMask);
    assign emitLast          = (count == CW'(K - 1)) ||
                               (headLast[selIdx] && (&(exhausted | selMask)));
    assign accept            = bus.in_valid & bus.in_ready;
    assign xfer              = (state == EMIT) && bus.out_ready;

    // State register; reset abandons any merge in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state and the handshake/status outputs that follow directly from state.
    always_comb begin
        nextState     = state;
        bus.in_ready  = '0;
        bus.out_valid = 1'b0;
        done          = 1'b0;
        loadOut       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = FILL;
                end
            end
            FILL: begin
                bus.in_ready = ~headFull & ~exhausted;
                if (allReady) begin
                    nextState = EMIT;
                    loadOut   = 1'b1;
                end
            end
            EMIT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (!bus.out_last) begin
                        nextState = FILL;
                    end else if (&exhaustedAfterPop) begin
                        nextState = DONE;
                    end else begin
                        nextState = FLUSH;
                    end
                end
            end
            FLUSH: begin
                bus.in_ready = ~headFull & ~exhausted;
                if (&exhausted) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Head registers, exhaustion tracking, result count and the registered result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headValue     <= '0;
            headName      <= '0;
            headLast      <= '0;
            headFull      <= '0;
            exhausted     <= '0;
            count         <= '0;
            bus.out_value <= '0;
            bus.out_name  <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                headFull  <= '0;
                exhausted <= '0;
                count     <= '0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (accept[c]) begin
                    if (state == FILL) begin
                        headValue[c*VAL_WIDTH +: VAL_WIDTH]   <= bus.in_value[c*VAL_WIDTH +: VAL_WIDTH];
                        headName[c*NAME_WIDTH +: NAME_WIDTH]  <= bus.in_name[c*NAME_WIDTH +: NAME_WIDTH];
                        headLast[c]                           <= bus.in_last[c];
                        headFull[c]                           <= 1'b1;
                    end else if (bus.in_last[c]) begin
                        // Flushing: entry is dropped, only its end marker matters.
                        exhausted[c] <= 1'b1;
                    end
                end
            end
            if (loadOut) begin
                bus.out_value <= headValue[selIdx*VAL_WIDTH +: VAL_WIDTH];
                bus.out_name  <= headName[selIdx*NAME_WIDTH +: NAME_WIDTH];
                bus.out_last  <= emitLast;
            end
            if (xfer) begin
                count        <= count + CW'(1);
                bus.out_last <= 1'b0;
                if (bus.out_last) begin
                    // Remaining heads are discarded; a discarded head that
                    // carried its list's end marker closes that channel.
                    headFull  <= '0;
                    exhausted <= exhaustedAfterPop | (headFull & headLast);
                end else begin
                    headFull  <= headFull & ~selMask;
                    exhausted <= exhaustedAfterPop;
                end
            end
        end
    end

`ifdef KSORT_MERGE_ORDER_CHECK_EN
    logic [NUM_CH*VAL_WIDTH-1:0] lastValue;
    logic [NUM_CH-1:0]           hasPrev;
    logic                        orderErrQ;

    // Sticky flag for any channel whose accepted values step downward within a merge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastValue <= '0;
            hasPrev   <= '0;
            orderErrQ <= 1'b0;
        end else if (state == IDLE && start) begin
            hasPrev   <= '0;
            orderErrQ <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (accept[c]) begin
                    if (hasPrev[c] &&
                        bus.in_value[c*VAL_WIDTH +: VAL_WIDTH] < lastValue[c*VAL_WIDTH +: VAL_WIDTH]) begin
                        orderErrQ <= 1'b1;
                    end
                    lastValue[c*VAL_WIDTH +: VAL_WIDTH] <= bus.in_value[c*VAL_WIDTH +: VAL_WIDTH];
                    hasPrev[c] <= 1'b1;
                end
            end
        end
    end

    assign order_err = orderErrQ;
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_ksort_merge.sv
// tb/tb_ksort_merge.sv - randomized scoreboard bench for ksort_merge
module tb_ksort_merge;
    localparam int VW  = 32;
    localparam int NW  = 32;
    localparam int NCH = 4;
    localparam int KK  = 4;
`ifdef KSORT_MERGE_ORDER_CHECK_EN
    localparam logic ORDER_EN = 1'b1;
`else
    localparam logic ORDER_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] v;
        logic [31:0] n;
        logic        last;
    } expT;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic done;
    logic order_err;

    ksort_merge_if #(.VAL_WIDTH(VW), .NAME_WIDTH(NW), .NUM_CH(NCH)) bus ();

    ksort_merge #(
        .VAL_WIDTH  (VW),
        .NAME_WIDTH (NW),
        .NUM_CH     (NCH),
        .K          (KK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .done      (done),
        .order_err (order_err)
    );

    always #5 clk = ~clk;

    logic [31:0]    chV [NCH][$];
    logic [31:0]    chN [NCH][$];
    int             gate [NCH];
    expT            expQ [$];
    logic [NCH-1:0] pend;
    int             curReady;
    int             gapPct;
    int             compared   = 0;
    int             mismatched = 0;
    int             doneCount  = 0;
    int             startDone  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One clock: retire entries handed over at this edge, then present the next ones.
    task automatic tick();
        pend = bus.in_valid & bus.in_ready;
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (pend[c]) begin
                void'(chV[c].pop_front());
                void'(chN[c].pop_front());
            end
            if (chV[c].size() > gate[c] && $urandom_range(0, 99) >= gapPct) begin
                bus.in_valid[c]             = 1'b1;
                bus.in_value[c*VW +: VW]    = chV[c][0];
                bus.in_name[c*NW +: NW]     = chN[c][0];
                bus.in_last[c]              = (chV[c].size() == 1);
            end else begin
                bus.in_valid[c] = 1'b0;
                bus.in_last[c]  = 1'b0;
            end
        end
        bus.out_ready = ($urandom_range(0, 99) < curReady);
    endtask

    task automatic clearLists();
        for (int c = 0; c < NCH; c++) begin
            chV[c].delete();
            chN[c].delete();
            gate[c] = 0;
        end
    endtask

    task automatic addEntry(input int c, input logic [31:0] v, input logic [31:0] n);
        chV[c].push_back(v);
        chN[c].push_back(n);
    endtask

    task automatic randomLists();
        int len;
        logic [31:0] v;
        clearLists();
        for (int c = 0; c < NCH; c++) begin
            len = $urandom_range(1, 3);
            v   = $urandom_range(0, 6);
            for (int p = 0; p < len; p++) begin
                addEntry(c, v, ($urandom & 32'hFFFF_0000) | 32'(c * 256 + p));
                v = v + $urandom_range(0, 4);
            end
        end
    endtask

    // Reference: the K smallest of all entries, equal values ordered by channel then position.
    task automatic pushModel();
        logic [31:0] av [$];
        logic [31:0] an [$];
        int take;
        int idx;
        for (int c = 0; c < NCH; c++) begin
            for (int p = 0; p < chV[c].size(); p++) begin
                av.push_back(chV[c][p]);
                an.push_back(chN[c][p]);
            end
        end
        take = (av.size() < KK) ? av.size() : KK;
        for (int i = 0; i < take; i++) begin
            idx = 0;
            for (int j = 1; j < av.size(); j++) begin
                if (av[j] < av[idx]) idx = j;
            end
            expQ.push_back('{v: av[idx], n: an[idx], last: (i == take - 1)});
            av.delete(idx);
            an.delete(idx);
        end
    endtask

    task automatic startMerge(input logic useModel);
        if (useModel) pushModel();
        startDone = doneCount;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finishMerge(input int budget, input logic expOrder);
        int remaining;
        for (int i = 0; i < budget && doneCount == startDone; i++) tick();
        tick();
        tick();
        remaining = 0;
        for (int c = 0; c < NCH; c++) remaining += chV[c].size();
        check("done_pulse_count", 64'(doneCount - startDone), 1);
        check("scoreboard_drained", 64'(expQ.size()), 0);
        check("inputs_flushed", 64'(remaining), 0);
        check("order_err", order_err, expOrder);
        expQ.delete();
    endtask

    task automatic waitOutValid(input int budget);
        for (int i = 0; i < budget && !bus.out_valid; i++) tick();
        check("out_valid_seen", bus.out_valid, 1);
    endtask

    // Monitor: a result is transferred at the next rising edge when valid and ready are both high now.
    always @(negedge clk) begin
        expT e;
        if (!reset) begin
            if (done) doneCount++;
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL extra_output: got value %0d, expected no output", bus.out_value);
                end else begin
                    e = expQ.pop_front();
                    check("out_value", bus.out_value, e.v);
                    check("out_name", bus.out_name, e.n);
                    check("out_last", bus.out_last, e.last);
                end
            end
        end
    end

    initial begin
        logic [31:0] hv;
        logic [31:0] hn;
        reset         = 1'b1;
        start         = 1'b0;
        bus.in_valid  = '0;
        bus.in_value  = '0;
        bus.in_name   = '0;
        bus.in_last   = '0;
        bus.out_ready = 1'b0;
        curReady      = 100;
        gapPct        = 0;
        pend          = '0;
        clearLists();

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_value", bus.out_value, 0);
        check("rst_out_name", bus.out_name, 0);
        check("rst_done", done, 0);
        check("rst_order_err", order_err, 0);
        reset = 1'b0;
        tick();

        // Basic merge with two channels left over to flush.
        clearLists();
        addEntry(0, 1, 32'h00); addEntry(0, 5, 32'h01);
        addEntry(1, 2, 32'h10); addEntry(1, 6, 32'h11);
        addEntry(2, 3, 32'h20);
        addEntry(3, 4, 32'h30);
        startMerge(1'b1);
        finishMerge(200, 1'b0);

        // Equal values: channel order decides.
        clearLists();
        for (int c = 0; c < NCH; c++) addEntry(c, 7, 32'(100 + c));
        startMerge(1'b1);
        finishMerge(200, 1'b0);

        // Backpressure: result held stable, a stray start is ignored.
        randomLists();
        curReady = 0;
        startMerge(1'b1);
        waitOutValid(100);
        hv = expQ[0].v;
        hn = expQ[0].n;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_out_value", bus.out_value, hv);
            check("bp_out_name", bus.out_name, hn);
            check("bp_in_ready", bus.in_ready, 0);
        end
        start    = 1'b0;
        curReady = 100;
        finishMerge(300, 1'b0);

        // Out-of-order channel 1 list {9,3}.
        clearLists();
        addEntry(0, 1, 32'h00);
        addEntry(1, 9, 32'h10); addEntry(1, 3, 32'h11);
        addEntry(2, 2, 32'h20);
        addEntry(3, 4, 32'h30);
        expQ.push_back('{v: 1, n: 32'h00, last: 1'b0});
        expQ.push_back('{v: 2, n: 32'h20, last: 1'b0});
        expQ.push_back('{v: 4, n: 32'h30, last: 1'b0});
        expQ.push_back('{v: 9, n: 32'h10, last: 1'b1});
        startMerge(1'b0);
        waitOutValid(100);
        check("order_err_before_3", order_err, 0);
        finishMerge(200, ORDER_EN);

        randomLists();
        startMerge(1'b1);
        check("order_err_cleared_by_start", order_err, 0);
        finishMerge(300, 1'b0);

        // Reset while stuck in flush: channel 0 withholds its last two entries.
        clearLists();
        addEntry(0, 1, 32'h00); addEntry(0, 5, 32'h01);
        addEntry(0, 7, 32'h02); addEntry(0, 8, 32'h03);
        addEntry(1, 2, 32'h10); addEntry(1, 6, 32'h11);
        addEntry(2, 3, 32'h20);
        addEntry(3, 4, 32'h30);
        gate[0] = 2;
        startMerge(1'b1);
        for (int i = 0; i < 200 && expQ.size() != 0; i++) tick();
        repeat (4) tick();
        check("flush_drained", 64'(expQ.size()), 0);
        check("flush_in_ready_ch0", bus.in_ready[0], 1);
        check("flush_no_done", 64'(doneCount - startDone), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_value", bus.out_value, 0);
        check("mid_rst_out_name", bus.out_name, 0);
        check("mid_rst_out_last", bus.out_last, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_order_err", order_err, 0);
        reset = 1'b0;
        clearLists();
        tick();
        tick();
        check("mid_rst_no_done", 64'(doneCount - startDone), 0);
        randomLists();
        startMerge(1'b1);
        finishMerge(300, 1'b0);

        // Randomized merges with input gaps and output backpressure.
        for (int r = 0; r < 25; r++) begin
            randomLists();
            gapPct   = $urandom_range(0, 50);
            curReady = $urandom_range(20, 100);
            startMerge(1'b1);
            finishMerge(400, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ksort_merge.md
KSORT_MERGE -- requirements
Module: ksort_merge

Interface
REQ-001 SHALL have parameter VAL_WIDTH, default 32, width of distance value.
REQ-002 SHALL have parameter NAME_WIDTH, default 32, width of training-vector name/index.
REQ-003 SHALL have parameter NUM_CH, default 4, number of sorted input channels (1..16).
REQ-004 SHALL have parameter K, default 8, number of nearest results emitted (1..255).
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse beginning a merge; ignored unless IDLE.
REQ-008 in_valid  in  NUM_CH  per-channel entry valid.
REQ-009 in_ready  out  NUM_CH  per-channel entry accepted when valid&ready.
REQ-010 in_value  in  NUM_CH*VAL_WIDTH  per-channel distance, channel c at [c*VAL_WIDTH +: VAL_WIDTH].
REQ-011 in_name  in  NUM_CH*NAME_WIDTH  per-channel name, same packing.
REQ-012 in_last  in  NUM_CH  marks final entry of a channel's ascending list.
REQ-013 out_valid / out_ready  out / in  1 each  result handshake, transfer on both high.
REQ-014 out_value / out_name  out  VAL_WIDTH / NAME_WIDTH  merged result.
REQ-015 out_last  out  1  marks final result of the merge.
REQ-016 done  out  1  one-cycle pulse when merge and input flush complete.
REQ-017 order_err  out  1  sticky input-ordering error flag (see Configuration).

Function
REQ-018 SHALL hold one head register (value, name, last, full) per channel; in_ready[c] = !head_full[c] && !exhausted[c] in FILL or FLUSH.
REQ-019 States IDLE, FILL, EMIT, FLUSH, DONE; IDLE->FILL on start, clearing heads, exhausted flags, output count.
REQ-020 FILL->EMIT the cycle after every non-exhausted channel has head_full; out_* registered from minimum head at that edge.
REQ-021 Minimum: smallest unsigned value; ties go to lowest channel index.
REQ-022 EMIT holds out_valid=1 and out_* stable until out_ready; on transfer, selected head popped, count incremented, exhausted set if popped head had last.
REQ-023 out_last=1 when count==K-1, or selected head has last and all other channels exhausted.
REQ-024 After out_last transfer: FLUSH if any channel not exhausted, else DONE; otherwise back to FILL.
REQ-025 FLUSH accepts and discards entries (in_ready high) until every channel has delivered in_last; then DONE.
REQ-026 DONE asserts done for exactly one cycle, then IDLE.
REQ-027 Throughput: at most one result per two cycles; first out_valid no earlier than 2 cycles after last head fills.
REQ-028 Each channel delivers at least one entry; fewer than K total entries yields fewer results with out_last on the final one.
REQ-029 start during non-IDLE states SHALL have no effect.

Reset
REQ-030 On reset: state IDLE; heads empty; exhausted cleared; count 0; in_ready, out_valid, out_last, done, order_err 0; out_value, out_name 0.
REQ-031 Reset mid-merge SHALL abandon the merge immediately; no done pulse is produced.

Configuration
REQ-032 Macro KSORT_MERGE_ORDER_CHECK_EN defined: per-channel last-accepted value register; order_err set sticky when a channel accepts a value smaller than its previous one in the same merge; cleared only by reset or start.
REQ-033 Macro undefined: no check registers; order_err tied 0.

Structure
REQ-034 Package ksort_pkg SHALL hold the state enumeration and CH_IDX_W = clog2(NUM_CH) / CNT_W = clog2(K+1) helper constants.
REQ-035 Sub-module ksort_min_sel SHALL implement the combinational argmin over NUM_CH heads (value, full mask -> index).

Verification
REQ-036 NUM_CH=4,K=4; ch0 {1,5}, ch1 {2,6}, ch2 {3}, ch3 {4}, out_ready=1 -> outputs 1,2,3,4, out_last on 4, ch0/ch1 flushed, done pulse.
REQ-037 Ties: ch0 {7}, ch1 {7}, ch2 {7}, ch3 {7}, K=8 -> names in channel order 0,1,2,3, out_last on 4th, no FLUSH.
REQ-038 Backpressure: out_ready low 5 cycles during EMIT -> out_value/out_name stable, no head popped, count unchanged.
REQ-039 Reset asserted during FLUSH -> all outputs 0 next edge, state IDLE, no done; fresh start merges correctly.
REQ-040 With KSORT_MERGE_ORDER_CHECK_EN, ch1 delivers {9,3} -> order_err rises after value 3 accepted and stays high until start; without macro, order_err stays 0.
